// File: rtl/cpu_ce_scheduler_if.sv
// cpu_ce_scheduler_if
// Groups the run-control inputs and the clock-enable/status outputs of the
// Z80 clock-enable scheduler into one bundle.
//   speed        [2:0]       requested divider code (period = speed+1 cycles)
//   run_mode     [1:0]       00 free, 01 paused, 10 slow tick, 11 paused
//   step                     single-step request (rising edge counted)
//   wait_n                   active-low wait, 0 withholds cpu_ce
//   cpu_ce                   one-cycle enable to the Z80/CTC/VDP bus logic
//   speed_active [2:0]       divider code currently in effect
//   paused                   run control is holding the CPU
//   ce_count     [CNT_W-1:0] cpu_ce pulses since reset, wrapping
// master: the controller side (OSD/debug overlay). slave: the scheduler.
interface cpu_ce_scheduler_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       speed;
    logic [1:0]       run_mode;
    logic             step;
    logic             wait_n;
    logic             cpu_ce;
    logic [2:0]       speed_active;
    logic             paused;
    logic [CNT_W-1:0] ce_count;

    modport master (
        output speed, run_mode, step, wait_n,
        input  cpu_ce, speed_active, paused, ce_count
    );

    modport slave (
        input  speed, run_mode, step, wait_n,
        output cpu_ce, speed_active, paused, ce_count
    );
endinterface

// File: rtl/cpu_ce_scheduler.sv
// cpu_ce_scheduler
// Generates the registered single-cycle Z80 clock enable from clk_sys with a
// selectable divide-by-(code+1), debug run control (free / pause / single
// step / slow tick) and wait-state stretching.
// Ports:
//   clk_sys  in   sole clock, rising edge
//   reset    in   synchronous, active-high
//   ctl      slave modport of cpu_ce_scheduler_if (see that file)
// Parameters:
//   SLOW_DIV clk_sys cycles between slow-mode ticks (2..2^24)
//   CNT_W    width of the exported cpu_ce event counter
module cpu_ce_scheduler #(
    parameter int SLOW_DIV = 2500000,
    parameter int CNT_W    = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    cpu_ce_scheduler_if.slave ctl
);
    localparam logic [23:0] PRE_RELOAD = 24'(SLOW_DIV - 1);

    logic             cpu_ce_q, cpu_ce_d;
    logic [2:0]       div_cnt_q, div_cnt_d;
    logic [2:0]       speed_active_q, speed_active_d;
    logic [CNT_W-1:0] ce_count_q, ce_count_d;
    logic             step_q;
    logic             step_pending_q, step_pending_d;
    logic             tick_pending_q, tick_pending_d;
    logic [23:0]      prescaler_q, prescaler_d;

    logic mode_free;
    logic mode_pause;
    logic mode_slow;
    logic term;
    logic gate;
    logic fire;
    logic step_edge;
    logic tick;

    assign mode_free  = (ctl.run_mode == 2'b00);
    assign mode_slow  = (ctl.run_mode == 2'b10);
    assign mode_pause = ctl.run_mode[0];          // 01 and 11 both pause
    assign term       = (div_cnt_q == speed_active_q);
    assign gate       = ctl.wait_n & (mode_free
                                      | (mode_pause & step_pending_q)
                                      | (mode_slow  & tick_pending_q));
    assign fire       = term & gate;
    assign step_edge  = ctl.step & ~step_q;
    assign tick       = mode_slow & (prescaler_q == 24'd0);

    always_comb begin
        cpu_ce_d       = 1'b0;
        div_cnt_d      = div_cnt_q;
        speed_active_d = speed_active_q;
        ce_count_d     = ce_count_q;

        if (fire) begin
            cpu_ce_d       = 1'b1;
            div_cnt_d      = 3'd0;
            speed_active_d = ctl.speed;
            ce_count_d     = ce_count_q + CNT_W'(1);
        end else if (term) begin
            // Held at terminal and retried every cycle. When run control is
            // holding, track the requested speed so resume uses it.
            if (!mode_free) begin
                speed_active_d = ctl.speed;
            end
        end else if (ctl.speed < div_cnt_q) begin
            // Code lowered below the current phase: restart the period at the
            // new code so it can never run past 8 cycles.
            div_cnt_d      = 3'd0;
            speed_active_d = ctl.speed;
        end else begin
            div_cnt_d = div_cnt_q + 3'd1;
        end
    end

    always_comb begin
        step_pending_d = step_pending_q;
        tick_pending_d = tick_pending_q;
        prescaler_d    = prescaler_q;

        // A consuming enable swallows a step edge arriving on the same cycle.
        if (!mode_pause || fire) begin
            step_pending_d = 1'b0;
        end else if (step_edge) begin
            step_pending_d = 1'b1;
        end

        if (!mode_slow) begin
            tick_pending_d = 1'b0;
            prescaler_d    = PRE_RELOAD;
        end else begin
            prescaler_d = tick ? PRE_RELOAD : (prescaler_q - 24'd1);
            if (fire) begin
                tick_pending_d = 1'b0;
            end else if (tick) begin
                tick_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_ce_q       <= 1'b0;
            div_cnt_q      <= 3'd0;
            speed_active_q <= ctl.speed;
            ce_count_q     <= '0;
            step_q         <= ctl.step;
            step_pending_q <= 1'b0;
            tick_pending_q <= 1'b0;
            prescaler_q    <= PRE_RELOAD;
        end else begin
            cpu_ce_q       <= cpu_ce_d;
            div_cnt_q      <= div_cnt_d;
            speed_active_q <= speed_active_d;
            ce_count_q     <= ce_count_d;
            step_q         <= ctl.step;
            step_pending_q <= step_pending_d;
            tick_pending_q <= tick_pending_d;
            prescaler_q    <= prescaler_d;
        end
    end

    assign ctl.cpu_ce       = cpu_ce_q;
    assign ctl.speed_active = speed_active_q;
    assign ctl.ce_count     = ce_count_q;
    assign ctl.paused       = ~mode_free & ~step_pending_q & ~tick_pending_q;
endmodule

// File: doc/cpu_ce_scheduler.md
Name: cpu_ce_scheduler

Overview:
- Generates the single-cycle Z80 clock-enable (cpu_ce) from clk_sys for the Rememotech core.
- Implements the OSD CPU-speed selection: divide-by-(code+1), so code 0 = 25 MHz and code 7 = 3.125 MHz at a 25 MHz clk_sys.
- Adds debug run control for the overlay workflow: free run, pause, single step and a slow-tick mode. This replaces ad-hoc clock slowing.
- Stretches CPU cycles while a memory or peripheral wait is pending.

Parameters:
- SLOW_DIV, 2500000: clk_sys cycles between slow-mode ticks (10 Hz at 25 MHz). Legal range 2..2^24.
- CNT_W, 16: width of the cpu_ce event counter exported to the debug overlay.

Ports:
- clk_sys  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- speed  in  3  requested divider code; period = speed+1 clk_sys cycles.
- run_mode  in  2  00 free, 01 paused, 10 slow, 11 treated as paused.
- step  in  1  single-step request; level or pulse, rising edge counted.
- wait_n  in  1  active-low wait; 0 withholds cpu_ce.
- cpu_ce  out  1  registered one-cycle enable to the Z80/CTC/VDP bus logic.
- speed_active  out  3  divider code currently in effect.
- paused  out  1  1 when run_mode ≠ 00 and no step or tick is pending.
- ce_count  out  CNT_W  number of cpu_ce pulses since reset; wraps.

Behaviour:
- Reset is synchronous. While reset=1: cpu_ce=0, div_cnt=0, speed_active<=speed, ce_count=0, step_pending=0, tick_pending=0, prescaler=SLOW_DIV-1, step_q<=step.
  - paused reflects run_mode combinationally with both pendings 0.
- div_cnt (3 bits) is the phase counter. Terminal (term) means div_cnt==speed_active.
- Gate is true when wait_n=1 and one of the following holds:
  - run_mode=00, or
  - run_mode=01/11 with step_pending=1, or
  - run_mode=10 with tick_pending=1.
- Each clk_sys edge:
  - If term and gate: cpu_ce<=1, div_cnt<=0, ce_count<=ce_count+1, speed_active<=speed, and the consumed pending flag is cleared.
  - Else if term: cpu_ce<=0 and div_cnt holds at terminal. The enable is retried every cycle; there is no phase slip beyond the wait.
  - Else: cpu_ce<=0, div_cnt<=div_cnt+1.
- Speed changes take effect only at an emitted cpu_ce, so no shortened or glitched period occurs.
  - Exception: while not term and speed < div_cnt (a lowered code mid-period), div_cnt wraps to 0 on the next edge. A period is never longer than 8 cycles.
  - While stalled in pause, speed_active also reloads every cycle at term, so the speed after resume is current.
- Timing with speed=3 in free run: after reset release, cpu_ce is high on edges 4, 8, 12, …
- Timing with speed=0: cpu_ce is high on every edge from edge 1.
- Step handling:
  - step_q registers step. A rising edge (step & ~step_q) sets step_pending only in run_mode 01/11 and only if it is 0. Multiple edges before consumption are coalesced.
  - step_pending produces exactly one cpu_ce, then clears.
- Slow mode:
  - prescaler decrements each cycle only while run_mode=10. At 0 it reloads SLOW_DIV-1 and sets tick_pending.
  - A tick that arrives while tick_pending=1 is dropped.
- Mode transitions:
  - Leaving 01/11 clears step_pending.
  - Leaving 10 clears tick_pending and reloads prescaler.
  - Entering 00 resumes at the current div_cnt phase.
- Simultaneous events:
  - Step edge and consumption on the same cycle: the consumption wins and the new edge is dropped.
  - wait_n=0 at term with a pending flag: the flag is kept until the cpu_ce is actually emitted.
- ce_count wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-period or mid-wait aborts immediately. The next cpu_ce follows the post-reset timing.

Test Plan:
- Free run, speed=3, wait_n=1, 40 cycles: cpu_ce on edges 4, 8, …, 40; ce_count=10.
- speed 7→1 changed 2 cycles after a cpu_ce: the current period completes at 8 cycles (or wraps per the rule), then the period is 2; speed_active=1 after that pulse; no period is ever <2 or >8.
- wait_n=0 held for 5 cycles across the term with speed=1: cpu_ce is delayed exactly until the first cycle with wait_n=1, then the following period is 2 cycles.
- run_mode=01: no cpu_ce for 100 cycles and paused=1. A 3-cycle-wide step pulse gives exactly one cpu_ce and ce_count +1. Two step pulses 1 cycle apart before consumption give one cpu_ce.
- run_mode=10 with SLOW_DIV=10 and speed=0: one cpu_ce every 10 cycles. Switching to 00 mid-count gives continuous cpu_ce, and tick_pending is cleared.
- Reset asserted 1 cycle after a step edge in pause: no cpu_ce, ce_count=0, step_pending=0 after release. Preload ce_count to 0xFFFF, then one cpu_ce gives ce_count=0.
